// File: rtl/uart_prog_loader.sv
// UART programming sequencer: parses a load frame (header, instruction words, data words,
// XOR checksum), writes words into programrom/data memory and answers with ACK or NAK.
module uart_prog_loader #(
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int MAX_WORDS      = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pg,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        busy,
  output logic        err
);
  // state | meaning
  // IDLE  | CPU owns the memories, waiting for start_pg
  // HDR   | collecting ICNT/DCNT header bytes
  // INST  | assembling instruction words -> programrom
  // DATA  | assembling data words -> data memory
  // CSUM  | waiting for the checksum byte
  // RESP  | presenting ACK/NAK until tx_ready
  typedef enum logic [2:0] {IDLE, HDR, INST, DATA, CSUM, RESP} state_t;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [13:0]   widx;
  logic [15:0]   icnt, dcnt;
  logic [31:0]   sreg, sreg_nxt;
  logic [7:0]    csum;
  logic [TW-1:0] tmr;
  logic          loading, acc, last_byte, timeout, word_wr, last_word, resp_set;
  logic [7:0]    resp_code;

  always_comb begin
    loading   = (state == HDR) || (state == INST) || (state == DATA) || (state == CSUM);
    acc       = loading && rx_valid;
    last_byte = (byte_cnt == 2'd3);
    sreg_nxt  = {rx_data, sreg[31:8]};
    timeout   = loading && !rx_valid && (tmr == '0);
    word_wr   = acc && last_byte && ((state == INST) || (state == DATA));
    last_word = (state == INST) ? ({2'b00, widx} == icnt - 16'd1)
                                : ({2'b00, widx} == dcnt - 16'd1);
    state_nxt = state;
    resp_set  = 1'b0;
    resp_code = NAK;
    case (state)
      IDLE: if (start_pg) state_nxt = HDR;
      HDR: begin
        if (acc && last_byte) begin
          if ((sreg_nxt[15:0] > MAX_W) || (sreg_nxt[31:16] > MAX_W)) begin
            state_nxt = RESP;
            resp_set  = 1'b1;
          end else if (sreg_nxt[15:0] != '0) begin
            state_nxt = INST;
          end else if (sreg_nxt[31:16] != '0) begin
            state_nxt = DATA;
          end else begin
            state_nxt = CSUM;
          end
        end
      end
      INST: if (word_wr && last_word) state_nxt = (dcnt != '0) ? DATA : CSUM;
      DATA: if (word_wr && last_word) state_nxt = CSUM;
      CSUM: begin
        if (acc) begin
          state_nxt = RESP;
          resp_set  = 1'b1;
          resp_code = (rx_data == csum) ? ACK : NAK;
        end
      end
      RESP: if (tx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // timeout only fires without rx_valid, so it never competes with an accepted byte
    if (timeout) begin
      state_nxt = RESP;
      resp_set  = 1'b1;
      resp_code = NAK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt   <= '0;
      widx       <= '0;
      icnt       <= '0;
      dcnt       <= '0;
      sreg       <= '0;
      csum       <= '0;
      tmr        <= TMR_LOAD;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b1;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      err        <= 1'b0;
    end else begin
      upg_wen_o <= word_wr;
      tx_valid  <= (state_nxt == RESP);
      if ((state == IDLE) && start_pg) begin
        upg_done_o <= 1'b0;
        err        <= 1'b0;
        byte_cnt   <= '0;
        widx       <= '0;
        csum       <= '0;
        tmr        <= TMR_LOAD;
      end
      if (acc) begin
        tmr <= TMR_LOAD;
        if (state != CSUM) begin
          byte_cnt <= byte_cnt + 2'd1;
          sreg     <= sreg_nxt;
          csum     <= csum ^ rx_data;
        end
      end else if (loading && (tmr != '0)) begin
        tmr <= tmr - TW'(1);
      end
      if ((state == HDR) && acc && last_byte) begin
        icnt <= sreg_nxt[15:0];
        dcnt <= sreg_nxt[31:16];
      end
      if (word_wr) begin
        upg_adr_o <= {(state == DATA), widx};
        upg_dat_o <= sreg_nxt;
        widx      <= last_word ? 14'd0 : widx + 14'd1;
      end
      if (resp_set) tx_data <= resp_code;
      if ((state == RESP) && tx_ready) begin
        upg_done_o <= 1'b1;
        err        <= (tx_data == NAK);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: each frame is planned at byte-position level (writes, response,
// response cycle) and a per-cycle monitor compares every output against that plan.
module tb_uart_prog_loader;
  localparam int T    = 100;
  localparam int MAXW = 16384;
  localparam int INF  = 1 << 30;

  logic        clk = 1'b0, rst = 1'b0, start_pg = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid, upg_wen_o, upg_done_o, busy, err;
  logic [7:0]  tx_data;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;

  uart_prog_loader #(.TIMEOUT_CYCLES(T), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start_pg(start_pg), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .upg_wen_o(upg_wen_o),
    .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o), .upg_done_o(upg_done_o), .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [14:0] adr; logic [31:0] dat; } wr_t;
  wr_t         exp_wr[$];
  logic [7:0]  g_fb[$];
  int          g_gap[$];
  int          g_nsend;
  int          s0 = INF, r_cyc = INF, h_cyc = INF;
  logic [7:0]  exp_code = 8'h00;
  logic        f_nak = 1'b0, prev_err = 1'b0;
  logic [14:0] last_adr = '0;
  logic [31:0] last_dat = '0;
  bit          in_rst = 1'b1;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, want);
    end
  endtask

  task automatic wait_cyc(input int target);
    if (target - cyc > 200000) begin
      $display("FAIL wait_bound at cycle %0d: got target %0d, want within budget", cyc, target);
      $fatal(1);
    end
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    bit   act_ld, txv, wen_e;
    logic e_err;
    if (in_rst) begin
      chk("rst_done", upg_done_o, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wen", upg_wen_o, 1'b0);
      chk("rst_txv", tx_valid, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_adr", upg_adr_o, 15'h0);
      chk("rst_dat", upg_dat_o, 32'h0);
      chk("rst_txd", tx_data, 8'h00);
    end else begin
      act_ld = (cyc >= s0) && (cyc < h_cyc);
      txv    = (cyc >= r_cyc) && (cyc < h_cyc);
      e_err  = (cyc >= h_cyc) ? f_nak : ((cyc >= s0) ? 1'b0 : prev_err);
      wen_e  = 1'b0;
      if (exp_wr.size() > 0)
        if (exp_wr[0].c == cyc) wen_e = 1'b1;
      chk("busy", busy, act_ld);
      chk("upg_done", upg_done_o, !act_ld);
      chk("tx_valid", tx_valid, txv);
      chk("err", err, e_err);
      chk("upg_wen", upg_wen_o, wen_e);
      if (wen_e) begin
        last_adr = exp_wr[0].adr;
        last_dat = exp_wr[0].dat;
        void'(exp_wr.pop_front());
      end
      chk("upg_adr", upg_adr_o, last_adr);
      chk("upg_dat", upg_dat_o, last_dat);
      if (txv) chk("tx_data", tx_data, exp_code);
    end
  end

  task automatic build_frame(input int hi, input int hd, input logic [31:0] ws[$],
                             input bit flip, output logic [7:0] fb[$]);
    logic [7:0] x;
    fb = {};
    fb.push_back(8'(hi));
    fb.push_back(8'(hi >> 8));
    fb.push_back(8'(hd));
    fb.push_back(8'(hd >> 8));
    foreach (ws[k]) for (int b = 0; b < 4; b++) fb.push_back(8'(ws[k] >> (8 * b)));
    x = 8'h00;
    foreach (fb[k]) x = x ^ fb[k];
    fb.push_back(flip ? (x ^ 8'h80) : x);
  endtask

  task automatic zero_gaps(input int n, output int g[$]);
    g = {};
    for (int k = 0; k < n; k++) g.push_back(0);
  endtask

  // Frame model: byte position decides its role; a gap longer than T since the last
  // accepted byte (or the start) is a timeout NAK at last+T.
  task automatic plan_frame(input logic [7:0] fb[$], input int gap[$], input int txd);
    int d, s, last, ni, nd, wi;
    logic [7:0] x;
    logic [14:0] a;
    bit done;
    g_fb = fb;
    g_gap = gap;
    prev_err = f_nak;
    s0 = cyc + 1;
    last = s0; d = cyc; x = 8'h00; ni = 0; nd = 0; done = 1'b0;
    g_nsend = fb.size(); r_cyc = INF; f_nak = 1'b1;
    exp_wr.delete();
    for (int i = 0; i < fb.size() && !done; i++) begin
      d = d + 1 + gap[i];
      s = d + 1;
      if (s > last + T) begin
        r_cyc = last + T; g_nsend = i; done = 1'b1;
      end else begin
        last = s;
        if (i >= 4 && i == 4 + 4 * (ni + nd)) begin
          r_cyc = s; f_nak = (fb[i] != x); g_nsend = i + 1; done = 1'b1;
        end else begin
          x = x ^ fb[i];
          if (i == 3) begin
            ni = int'({fb[1], fb[0]});
            nd = int'({fb[3], fb[2]});
            if (ni > MAXW || nd > MAXW) begin
              r_cyc = s; g_nsend = 4; done = 1'b1;
            end
          end else if (i >= 4 && (i - 4) % 4 == 3) begin
            wi = (i - 4) / 4;
            a = (wi < ni) ? 15'(wi) : 15'(16384 + wi - ni);
            exp_wr.push_back('{s, a, {fb[i], fb[i-1], fb[i-2], fb[i-3]}});
          end
        end
      end
    end
    if (!done) r_cyc = last + T;
    exp_code = f_nak ? 8'h15 : 8'h06;
    h_cyc = r_cyc + txd + 1;
  endtask

  task automatic drive_frame(input int abort_after, input bit junk);
    int d, n;
    n = g_nsend;
    if (abort_after >= 0 && abort_after < n) n = abort_after;
    start_pg = 1'b1;
    wait_cyc(s0);
    start_pg = 1'b0;
    d = s0 - 1;
    for (int i = 0; i < n; i++) begin
      d = d + 1 + g_gap[i];
      wait_cyc(d);
      rx_valid = 1'b1;
      rx_data  = g_fb[i];
      start_pg = junk && ($urandom_range(0, 7) == 0);
      wait_cyc(d + 1);
      rx_valid = 1'b0;
      start_pg = 1'b0;
    end
    if (abort_after >= 0) begin
      rst = 1'b0;
      in_rst = 1'b1;
      #1;
      chk("abort_wen", upg_wen_o, 1'b0);
      chk("abort_adr", upg_adr_o, 15'h0);
      chk("abort_dat", upg_dat_o, 32'h0);
      chk("abort_txv", tx_valid, 1'b0);
      chk("abort_done", upg_done_o, 1'b1);
      chk("abort_busy", busy, 1'b0);
      s0 = INF; r_cyc = INF; h_cyc = INF; f_nak = 1'b0; prev_err = 1'b0;
      last_adr = '0; last_dat = '0;
      exp_wr.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      in_rst = 1'b0;
      return;
    end
    for (int c = r_cyc; c < h_cyc; c++) begin
      wait_cyc(c);
      rx_valid = junk && ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      tx_ready = (c == h_cyc - 1);
    end
    wait_cyc(h_cyc);
    tx_ready = 1'b0;
    for (int c = h_cyc; c < h_cyc + 4; c++) begin
      wait_cyc(c);
      rx_valid = junk && ($urandom_range(0, 1) == 0);
      rx_data  = 8'($urandom);
    end
    wait_cyc(h_cyc + 4);
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  fb[$];
    int          gp[$];
    logic [31:0] ws[$];
    int          ni, nd, kind, k;
    bit          flip;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", upg_done_o, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", err, 1'b0);
    rst = 1'b1;
    in_rst = 1'b0;
    wait_cyc(cyc + 2);

    // good frame, rx every cycle
    ws = '{32'h00500093, 32'h00100113, 32'hDEADBEEF};
    build_frame(2, 1, ws, 1'b0, fb);
    zero_gaps(fb.size(), gp);
    plan_frame(fb, gp, 0);
    chk("pin_f1_nwr", exp_wr.size(), 3);
    chk("pin_f1_adr0", exp_wr[0].adr, 15'h0000);
    chk("pin_f1_dat0", exp_wr[0].dat, 32'h00500093);
    chk("pin_f1_adr1", exp_wr[1].adr, 15'h0001);
    chk("pin_f1_dat1", exp_wr[1].dat, 32'h00100113);
    chk("pin_f1_adr2", exp_wr[2].adr, 15'h4000);
    chk("pin_f1_dat2", exp_wr[2].dat, 32'hDEADBEEF);
    chk("pin_f1_code", exp_code, 8'h06);
    chk("pin_f1_lat", r_cyc - s0, 17);
    drive_frame(-1, 1'b0);
    chk("f1_err", err, 1'b0);
    chk("f1_done", upg_done_o, 1'b1);

    // same frame, corrupted checksum
    build_frame(2, 1, ws, 1'b1, fb);
    plan_frame(fb, gp, 0);
    chk("pin_f2_nwr", exp_wr.size(), 3);
    chk("pin_f2_code", exp_code, 8'h15);
    drive_frame(-1, 1'b0);
    chk("f2_err", err, 1'b1);

    // empty frame
    ws.delete();
    build_frame(0, 0, ws, 1'b0, fb);
    zero_gaps(fb.size(), gp);
    plan_frame(fb, gp, 1);
    chk("pin_f3_nwr", exp_wr.size(), 0);
    chk("pin_f3_code", exp_code, 8'h06);
    chk("pin_f3_lat", r_cyc - s0, 5);
    drive_frame(-1, 1'b0);
    chk("f3_err", err, 1'b0);

    // ICNT over capacity
    build_frame(16'h4001, 0, ws, 1'b0, fb);
    plan_frame(fb, gp, 0);
    chk("pin_f4_nwr", exp_wr.size(), 0);
    chk("pin_f4_code", exp_code, 8'h15);
    chk("pin_f4_lat", r_cyc - s0, 4);
    drive_frame(-1, 1'b1);

    // timeout after one word plus two bytes
    ws = '{32'h00500093, 32'h00100113, 32'hDEADBEEF};
    build_frame(2, 1, ws, 1'b0, fb);
    while (fb.size() > 10) void'(fb.pop_back());
    zero_gaps(fb.size(), gp);
    plan_frame(fb, gp, 0);
    chk("pin_to_nwr", exp_wr.size(), 1);
    chk("pin_to_lat", r_cyc - s0, 10 + T);
    chk("pin_to_code", exp_code, 8'h15);
    drive_frame(-1, 1'b0);
    chk("to_err", err, 1'b1);

    // byte arriving on the last idle cycle wins over the timeout
    build_frame(2, 1, ws, 1'b0, fb);
    zero_gaps(fb.size(), gp);
    gp[9] = T - 1;
    plan_frame(fb, gp, 0);
    chk("pin_edge_code", exp_code, 8'h06);
    chk("pin_edge_lat", r_cyc - s0, 17 + T - 1);
    drive_frame(-1, 1'b0);
    gp[9] = T;
    plan_frame(fb, gp, 0);
    chk("pin_edge2_code", exp_code, 8'h15);
    chk("pin_edge2_lat", r_cyc - s0, 9 + T);
    drive_frame(-1, 1'b0);

    // ICNT exactly at capacity is accepted; load then starves
    ws = '{32'h11223344, 32'h55667788};
    build_frame(16'h4000, 0, ws, 1'b0, fb);
    while (fb.size() > 12) void'(fb.pop_back());
    zero_gaps(fb.size(), gp);
    plan_frame(fb, gp, 0);
    chk("pin_max_nwr", exp_wr.size(), 2);
    chk("pin_max_lat", r_cyc - s0, 12 + T);
    drive_frame(-1, 1'b0);

    // reset after 5 data bytes, then a clean frame with a slow transmitter
    ws = '{32'h00500093, 32'h00100113, 32'hDEADBEEF};
    build_frame(2, 1, ws, 1'b0, fb);
    zero_gaps(fb.size(), gp);
    plan_frame(fb, gp, 0);
    drive_frame(9, 1'b0);
    plan_frame(fb, gp, 10);
    chk("pin_slow_code", exp_code, 8'h06);
    drive_frame(-1, 1'b1);
    chk("slow_err", err, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ni   = $urandom_range(0, 3);
      nd   = $urandom_range(0, 3);
      flip = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 9);
      ws.delete();
      for (int w = 0; w < ni + nd; w++) ws.push_back($urandom);
      if (kind == 0) build_frame(16385 + $urandom_range(0, 100), nd, ws, flip, fb);
      else           build_frame(ni, nd, ws, flip, fb);
      if (kind == 1) begin
        k = $urandom_range(1, fb.size() - 1);
        while (fb.size() > k) void'(fb.pop_back());
      end
      gp = {};
      foreach (fb[i]) begin
        k = $urandom_range(0, 19);
        gp.push_back((k < 14) ? 0 : (k < 18) ? $urandom_range(1, 4) : (k == 18) ? T - 1 : 0);
      end
      if (kind == 2) gp[$urandom_range(0, fb.size() - 1)] = T + $urandom_range(0, 3);
      plan_frame(fb, gp, $urandom_range(0, 4));
      drive_frame(-1, 1'b1);
    end

    wait_cyc(cyc + 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d: got no finish, want finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Sequencer that owns the UART programming path into the instruction ROM and data memory. It takes the received byte stream, parses a fixed header, assembles little-endian 32-bit words and issues write pulses on the upg_* port of programrom or memory. It holds the CPU off via upg_done_o while loading and returns a one-byte ACK/NAK on the UART transmit side. It sits between the UART receiver/transmitter and the two memories' upg_* inputs; it does not implement the UART PHY.

## Interface
- TIMEOUT_CYCLES, 10_000_000: idle-byte limit during a load before aborting.
- MAX_WORDS, 16384: per-memory word capacity (14-bit word address).
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_pg  in  1  load request, level, sampled each cycle; acted on only in IDLE.
- rx_valid  in  1  one-cycle strobe, rx_data valid; at most one byte per cycle.
- rx_data  in  8  received byte.
- tx_ready  in  1  transmitter can accept a byte.
- tx_valid  out  1  ACK/NAK byte valid; held until tx_ready.
- tx_data  out  8  0x06 ACK, 0x15 NAK.
- upg_wen_o  out  1  one-cycle memory write strobe.
- upg_adr_o  out  15  [14]=0 programrom, 1 data memory; [13:0] word address.
- upg_dat_o  out  32  write data.
- upg_done_o  out  1  1 = CPU may run, memories owned by CPU; 0 = load in progress.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky flag from the last load: 1 = NAK'd; cleared on the next start_pg accept.

## Operation
- Frame: header of 4 bytes (ICNT[7:0], ICNT[15:8], DCNT[7:0], DCNT[15:8]), then ICNT instruction words, then DCNT data words, each word 4 bytes little-endian, then 1 checksum byte = XOR of every preceding frame byte, header included.
- States: IDLE, HDR, INST, DATA, CSUM, RESP.
- IDLE: start_pg=1 -> HDR. On entry: upg_done_o<=0, byte/word counters cleared, checksum cleared, err cleared.
- HDR: collect 4 bytes.
  - If ICNT>MAX_WORDS or DCNT>MAX_WORDS -> RESP with NAK.
  - Else go to INST if ICNT≠0, else DATA if DCNT≠0, else CSUM.
- INST / DATA:
  - Shift bytes into the word register, LSB first.
  - On the 4th byte, issue a write: INST to address {1'b0, widx}, DATA to address {1'b1, widx}, then widx++.
  - After the last word, widx resets to 0 and the FSM goes to DATA (or to CSUM if DCNT=0).
- CSUM: one byte. If it equals the running XOR -> RESP with ACK, else RESP with NAK.
- RESP: tx_valid=1 with tx_data held until tx_ready=1. Then upg_done_o<=1, err<=(NAK), -> IDLE.
- Timeout: in HDR/INST/DATA/CSUM, an idle counter reloads on every rx_valid. When TIMEOUT_CYCLES elapse with no byte -> RESP with NAK.
- Aborted loads leave already-written words in memory. No rollback.
- rx_valid in IDLE or RESP: byte is ignored and not counted. start_pg outside IDLE: ignored.
- Reset mid-load: all state to reset values immediately. Partially loaded memory is not repaired; upg_done_o returns to 1.

## Timing
- Reset values: upg_done_o=1, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, tx_valid=0, tx_data=0, busy=0, err=0, state IDLE.
- start_pg sampled high in IDLE -> upg_done_o=0 and busy=1 on the next cycle.
- Word write: upg_wen_o is high for exactly the one cycle after the clock edge that accepts the 4th rx byte. upg_adr_o and upg_dat_o are stable that cycle and hold until the next write.
- Back-to-back rx_valid every cycle is supported: a write occurs every 4 cycles with no stall.
- tx_valid asserts the cycle after the checksum byte is accepted, or the cycle after the NAK condition is detected.
- Handshake completes on the edge where tx_valid and tx_ready are both high. On that same edge upg_done_o goes to 1 and busy to 0.
- Timeout fires on the cycle the idle count reaches TIMEOUT_CYCLES-1 with no rx_valid. An rx_valid on that same cycle wins: the byte is accepted and no timeout occurs.

## Test plan
- Frame ICNT=2, DCNT=1, words 0x00500093, 0x00100113, data 0xDEADBEEF, correct checksum, rx_valid every cycle:
  - writes (adr 0x0000, 0x00500093), (0x0001, 0x00100113), (0x4000, 0xDEADBEEF);
  - then tx_data=0x06; upg_done_o returns to 1; err=0.
- Same frame with checksum bit-flipped: same three writes, then tx_data=0x15, err=1.
- Header ICNT=0, DCNT=0, checksum 0x00: no upg_wen_o pulse; ACK 0x06.
- Header ICNT=0x4001: NAK right after the 4th header byte; no writes.
- After 1 word plus 2 bytes, stop rx for TIMEOUT_CYCLES (set to 100 in bench): NAK at cycle 100; only adr 0x0000 written.
- Both of these mid-load:
  - assert rst=0 after 5 data bytes: all outputs at reset values immediately; upg_done_o=1;
  - a subsequent clean frame with tx_ready held low for 10 cycles: tx_valid holds with data stable, and upg_done_o stays 0 until the handshake.
